cpu_fetch_unit: RTL

//  Q1 instruction fetch front-end for the 5-stage core; replaces direct PC->insnmem indexing.

---
 rtl/cpu_fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: instruction fetch front-end with imem request credit, prefetch FIFO and redirect flush.
// Define CPU_FETCH_PERF_EN to add saturating accepted-fetch and dropped-response counters.
module cpu_fetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_imem_rsp_err,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_insn_valid,
  input  logic        i_insn_ready,
  output logic [31:0] o_insn,
  output logic [31:0] o_insn_pc,
  output logic [31:0] o_insn_pc_incr,
  output logic        o_insn_fault
`ifdef CPU_FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_drop_cnt
`endif
);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {RUN, HALT} state_t;
  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, pend_addr_q;
  logic          pend_q, stale_q;
  logic [CW-1:0] in_flight_q, in_flight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr_idx;
  logic [31:0]   mem_insn [DEPTH];
  logic [31:0]   mem_pc [DEPTH];
  logic          mem_fault [DEPTH];
  logic [31:0]   hold_insn_q, hold_pc_q, wr_insn, wr_pc;
  logic          hold_fault_q, wr_fault, wr_en;
  logic          issue_ok, accept, stale_acc, push, pop, misalign;
  // Request issue gated by credit; a request already presented stays up until accepted,
  // and one that was pending across a redirect is accepted and its response discarded.
  always_comb begin
    issue_ok = state_q == RUN && !i_redirect && in_flight_q < CW'(MAX_OUTSTANDING) &&
               ({1'b0, count_q} + {1'b0, in_flight_q}) < (CW + 1)'(DEPTH);
    o_imem_req_valid = pend_q | (!i_rst & issue_ok);
    o_imem_req_addr  = pend_q ? pend_addr_q : fetch_pc_q;
    accept    = o_imem_req_valid & i_imem_req_ready;
    stale_acc = accept & (i_redirect | stale_q);
    push      = i_imem_rsp_valid && drop_q == '0 && !i_redirect;
    o_insn_valid = count_q != '0;
    pop       = o_insn_valid & i_insn_ready & !i_redirect;
    misalign  = i_redirect & |i_redirect_pc[1:0];
    in_flight_d = in_flight_q + CW'(accept) - CW'(i_imem_rsp_valid);
    drop_d    = i_redirect ? in_flight_d
                           : drop_q - CW'(i_imem_rsp_valid && drop_q != '0) + CW'(stale_acc);
    fetch_pc_d = i_redirect ? i_redirect_pc : (accept && !stale_acc) ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d  = i_redirect ? i_redirect_pc : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    state_d   = i_redirect ? (misalign ? HALT : RUN) : (push && i_imem_rsp_err) ? HALT : state_q;
    count_d   = i_redirect ? CW'(misalign) : count_q + CW'(push) - CW'(pop);
    rd_d      = i_redirect ? '0 : rd_q + PW'(pop);
    wr_d      = i_redirect ? PW'(misalign) : wr_q + PW'(push);
    wr_en     = push | misalign;
    wr_idx    = i_redirect ? '0 : wr_q;
    wr_fault  = misalign | i_imem_rsp_err;
    wr_insn   = wr_fault ? NOP : i_imem_rsp_data;
    wr_pc     = i_redirect ? i_redirect_pc : rsp_pc_q;
    o_insn       = o_insn_valid ? mem_insn[rd_q] : hold_insn_q;
    o_insn_pc    = o_insn_valid ? mem_pc[rd_q] : hold_pc_q;
    o_insn_fault = o_insn_valid ? mem_fault[rd_q] : hold_fault_q;
    o_insn_pc_incr = o_insn_pc + 32'd4;
  end
  // Control state, pointers and last-presented output values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      pend_addr_q  <= RESET_PC;
      pend_q       <= 1'b0;
      stale_q      <= 1'b0;
      in_flight_q  <= '0;
      drop_q       <= '0;
      count_q      <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      hold_insn_q  <= NOP;
      hold_pc_q    <= '0;
      hold_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      pend_addr_q <= o_imem_req_addr;
      pend_q      <= o_imem_req_valid & !i_imem_req_ready;
      stale_q     <= o_imem_req_valid & !i_imem_req_ready & (i_redirect | stale_q);
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      if (o_insn_valid) begin
        hold_insn_q  <= o_insn;
        hold_pc_q    <= o_insn_pc;
        hold_fault_q <= o_insn_fault;
      end
    end
  end
  // Prefetch FIFO storage; entries are only read while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_insn[wr_idx]  <= wr_insn;
      mem_pc[wr_idx]    <= wr_pc;
      mem_fault[wr_idx] <= wr_fault;
    end
  end
`ifdef CPU_FETCH_PERF_EN
  // Saturating counts of accepted requests and discarded responses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_fetch_cnt <= '0;
      o_perf_drop_cnt  <= '0;
    end else begin
      if (accept && o_perf_fetch_cnt != '1) o_perf_fetch_cnt <= o_perf_fetch_cnt + 32'd1;
      if (i_imem_rsp_valid && !push && o_perf_drop_cnt != '1) o_perf_drop_cnt <= o_perf_drop_cnt + 32'd1;
    end
  end
`endif
endmodule
